// File: rtl/iob_cache_write_buffer.sv
// Write buffer between the cache front end and the memory write channel: a first-word-fall-through
// FIFO of {addr, wdata, wstrb}. Optional same-address write merging with `define IOB_CACHE_WBUF_MERGE_EN.
module iob_cache_write_buffer #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int DEPTH_W = 2,
    localparam int NBYTES  = DATA_W / 8,
    localparam int WADDR_W = ADDR_W - $clog2(NBYTES)
) (
    input  logic               clk_i,
    input  logic               arst_n_i,
    input  logic               fe_valid_i,
    input  logic [WADDR_W-1:0] fe_addr_i,
    input  logic [DATA_W-1:0]  fe_wdata_i,
    input  logic [NBYTES-1:0]  fe_wstrb_i,
    output logic               fe_ready_o,
    output logic               valid_o,
    output logic [WADDR_W-1:0] addr_o,
    output logic [DATA_W-1:0]  wdata_o,
    output logic [NBYTES-1:0]  wstrb_o,
    input  logic               ready_i,
    output logic               empty_o,
    output logic               full_o,
    output logic [DEPTH_W:0]   level_o
);

    localparam int DEPTH = 2 ** DEPTH_W;
    localparam logic [DEPTH_W:0]   LEVEL_ONE  = {{DEPTH_W{1'b0}}, 1'b1};
    localparam logic [DEPTH_W:0]   LEVEL_FULL = {1'b1, {DEPTH_W{1'b0}}};
    localparam logic [DEPTH_W-1:0] PTR_ONE    = {{(DEPTH_W-1){1'b0}}, 1'b1};

    logic [WADDR_W-1:0] addr_mem_q [DEPTH];
    logic [DATA_W-1:0]  data_mem_q [DEPTH];
    logic [NBYTES-1:0]  strb_mem_q [DEPTH];

    logic [DEPTH_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_W:0]   level_q, level_d;
    logic               empty_q, empty_d;
    logic               full_q, full_d;

    logic               push_s;
    logic               pop_s;
    logic               merge_s;
    logic               alloc_s;
    logic [DEPTH_W-1:0] wr_idx_s;
    logic [DATA_W-1:0]  wdata_wr_s;
    logic [NBYTES-1:0]  wstrb_wr_s;

    assign push_s  = fe_valid_i & ~full_q;
    assign pop_s   = ready_i & ~empty_q;
    assign alloc_s = push_s & ~merge_s;

`ifdef IOB_CACHE_WBUF_MERGE_EN
    logic [DEPTH_W-1:0] newest_s;
    assign newest_s = wr_ptr_q - PTR_ONE;
    // The newest entry may absorb the write unless it is the sole entry and is leaving this cycle.
    assign merge_s = push_s & ~empty_q & (addr_mem_q[newest_s] == fe_addr_i) &
                     ~(pop_s & (level_q == LEVEL_ONE));
`else
    assign merge_s = 1'b0;
`endif

    // Select the storage slot and the byte-merged payload for this cycle's write.
    always_comb begin
        wr_idx_s   = wr_ptr_q;
        wdata_wr_s = fe_wdata_i;
        wstrb_wr_s = fe_wstrb_i;
`ifdef IOB_CACHE_WBUF_MERGE_EN
        if (merge_s) begin
            wr_idx_s   = newest_s;
            wstrb_wr_s = fe_wstrb_i | strb_mem_q[newest_s];
            for (int b = 0; b < NBYTES; b++) begin
                wdata_wr_s[b*8 +: 8] = fe_wstrb_i[b] ? fe_wdata_i[b*8 +: 8]
                                                     : data_mem_q[newest_s][b*8 +: 8];
            end
        end else begin
            wr_idx_s = wr_ptr_q;
        end
`endif
    end

    // Next pointers, occupancy and flags.
    always_comb begin
        wr_ptr_d = alloc_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        rd_ptr_d = pop_s ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
        case ({alloc_s, pop_s})
            2'b10:   level_d = level_q + LEVEL_ONE;
            2'b01:   level_d = level_q - LEVEL_ONE;
            default: level_d = level_q;
        endcase
        empty_d = (level_d == {(DEPTH_W + 1){1'b0}});
        full_d  = (level_d == LEVEL_FULL);
    end

    // Control state register; storage contents survive reset on purpose.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            wr_ptr_q <= {DEPTH_W{1'b0}};
            rd_ptr_q <= {DEPTH_W{1'b0}};
            level_q  <= {(DEPTH_W + 1){1'b0}};
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
        end
    end

    // Entry storage write port.
    always_ff @(posedge clk_i) begin
        if (push_s) begin
            addr_mem_q[wr_idx_s] <= fe_addr_i;
            data_mem_q[wr_idx_s] <= wdata_wr_s;
            strb_mem_q[wr_idx_s] <= wstrb_wr_s;
        end
    end

    assign fe_ready_o = ~full_q;
    assign valid_o    = ~empty_q;
    assign empty_o    = empty_q;
    assign full_o     = full_q;
    assign level_o    = level_q;
    assign addr_o     = addr_mem_q[rd_ptr_q];
    assign wdata_o    = data_mem_q[rd_ptr_q];
    assign wstrb_o    = strb_mem_q[rd_ptr_q];

endmodule

// File: tb/tb_iob_cache_write_buffer.sv
// Scoreboard bench for iob_cache_write_buffer: the driver keeps a queue of expected entries,
// a monitor compares flags and the head entry every cycle and retires entries on handshakes.
module tb_iob_cache_write_buffer;

    localparam int DEPTH = 4;

    typedef struct {
        logic [29:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } ent_t;

    logic        clk_i = 1'b0;
    logic        arst_n_i = 1'b0;
    logic        fe_valid_i = 1'b0;
    logic [29:0] fe_addr_i = 30'h0;
    logic [31:0] fe_wdata_i = 32'h0;
    logic [3:0]  fe_wstrb_i = 4'h0;
    logic        fe_ready_o;
    logic        valid_o;
    logic [29:0] addr_o;
    logic [31:0] wdata_o;
    logic [3:0]  wstrb_o;
    logic        ready_i = 1'b0;
    logic        empty_o;
    logic        full_o;
    logic [2:0]  level_o;

    int   vectors = 0;
    int   miscompares = 0;
    ent_t exp_q[$];

    iob_cache_write_buffer dut (
        .clk_i(clk_i), .arst_n_i(arst_n_i),
        .fe_valid_i(fe_valid_i), .fe_addr_i(fe_addr_i), .fe_wdata_i(fe_wdata_i),
        .fe_wstrb_i(fe_wstrb_i), .fe_ready_o(fe_ready_o),
        .valid_o(valid_o), .addr_o(addr_o), .wdata_o(wdata_o), .wstrb_o(wstrb_o),
        .ready_i(ready_i), .empty_o(empty_o), .full_o(full_o), .level_o(level_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One bus cycle: drive at negedge, predict acceptance/merge from the model, commit at posedge.
    task automatic cycle(input logic v, input logic [29:0] a, input logic [31:0] d,
                         input logic [3:0] s, input logic r);
        int   sz;
        bit   acc, popp, mrg;
        ent_t e;
        @(negedge clk_i);
        fe_valid_i = v; fe_addr_i = a; fe_wdata_i = d; fe_wstrb_i = s; ready_i = r;
        sz   = exp_q.size();
        acc  = v && (sz < DEPTH);
        popp = r && (sz > 0);
        mrg  = 1'b0;
`ifdef IOB_CACHE_WBUF_MERGE_EN
        if (acc && sz > 0 && exp_q[sz-1].addr == a && !(sz == 1 && popp)) mrg = 1'b1;
`endif
        @(posedge clk_i);
        if (mrg) begin
            e = exp_q[exp_q.size()-1];
            for (int b = 0; b < 4; b++) if (s[b]) e.data[b*8 +: 8] = d[b*8 +: 8];
            e.strb = e.strb | s;
            exp_q[exp_q.size()-1] = e;
        end else if (acc) begin
            e.addr = a; e.data = d; e.strb = s;
            exp_q.push_back(e);
        end
    endtask

    task automatic idle(input logic r);
        cycle(1'b0, 30'h0, 32'h0, 4'h0, r);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_level"}, 64'(level_o), 64'd0);
        chk({tag, "_empty"}, 64'(empty_o), 64'd1);
        chk({tag, "_full"}, 64'(full_o), 64'd0);
        chk({tag, "_valid"}, 64'(valid_o), 64'd0);
        chk({tag, "_fe_ready"}, 64'(fe_ready_o), 64'd1);
    endtask

    // Monitor: mid-cycle compare of flags and head; retire the head on a handshake.
    initial begin
        forever begin
            @(negedge clk_i);
            #2;
            if (arst_n_i) begin
                int sz;
                sz = exp_q.size();
                chk("level", 64'(level_o), 64'(sz));
                chk("valid", 64'(valid_o), 64'(sz != 0));
                chk("empty", 64'(empty_o), 64'(sz == 0));
                chk("full", 64'(full_o), 64'(sz == DEPTH));
                chk("fe_ready", 64'(fe_ready_o), 64'(sz != DEPTH));
                if (sz > 0) begin
                    chk("head_addr", 64'(addr_o), 64'(exp_q[0].addr));
                    chk("head_wdata", 64'(wdata_o), 64'(exp_q[0].data));
                    chk("head_wstrb", 64'(wstrb_o), 64'(exp_q[0].strb));
                    if (ready_i) void'(exp_q.pop_front());
                end
            end
        end
    end

    // Driver: directed scenarios followed by randomized traffic.
    initial begin
        repeat (2) @(negedge clk_i);
        check_reset_state("por");
        arst_n_i = 1'b1;

        // Single push held at head until consumed.
        cycle(1'b1, 30'h10, 32'hAABBCCDD, 4'hF, 1'b0);
        repeat (3) idle(1'b0);
        idle(1'b1);
        idle(1'b0);

        // Fill to full, refused fifth write, then drain in order.
        for (int i = 0; i < 4; i++) cycle(1'b1, 30'(16'h100 + i), 32'(32'h1000 * (i + 1)), 4'hF, 1'b0);
        cycle(1'b1, 30'h1FF, 32'hDEADBEEF, 4'hF, 1'b0);
        cycle(1'b1, 30'h1FE, 32'hCAFEF00D, 4'hF, 1'b1);
        repeat (6) idle(1'b1);

        // Simultaneous push and pop at level 2.
        cycle(1'b1, 30'h200, 32'h11111111, 4'hF, 1'b0);
        cycle(1'b1, 30'h201, 32'h22222222, 4'hF, 1'b0);
        cycle(1'b1, 30'h202, 32'h33333333, 4'hF, 1'b1);
        repeat (4) idle(1'b1);

        // Two writes to the same word: merged or separate entries depending on the build.
        cycle(1'b1, 30'h20, 32'h000000AA, 4'h1, 1'b0);
        cycle(1'b1, 30'h20, 32'h0000BB00, 4'h2, 1'b0);
        idle(1'b0);
        repeat (3) idle(1'b1);

        // Asynchronous reset at level 3 discards everything.
        for (int i = 0; i < 3; i++) cycle(1'b1, 30'(16'h300 + i), 32'(32'h5A5A0000 + i), 4'hF, 1'b0);
        @(negedge clk_i);
        fe_valid_i = 1'b0; ready_i = 1'b0;
        #1 arst_n_i = 1'b0;
        #1 check_reset_state("mid_rst");
        exp_q.delete();
        @(negedge clk_i);
        arst_n_i = 1'b1;
        cycle(1'b1, 30'h3AB, 32'h0BADCAFE, 4'hC, 1'b0);
        idle(1'b0);
        repeat (2) idle(1'b1);

        // Randomized traffic over a small address set to provoke same-address writes.
        for (int n = 0; n < 400; n++) begin
            cycle(1'($urandom_range(0, 1)), 30'($urandom_range(0, 3)), $urandom,
                  4'($urandom_range(0, 15)), 1'($urandom_range(0, 2) != 0));
        end
        repeat (8) idle(1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/iob_cache_write_buffer.md
IOB_CACHE_WRITE_BUFFER -- requirements
Module: iob_cache_write_buffer

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, byte-address width.
REQ-002 SHALL have parameter DATA_W, default 32, front-end word width, multiple of 8; NBYTES=DATA_W/8, WADDR_W=ADDR_W-log2(NBYTES).
REQ-003 SHALL have parameter DEPTH_W, default 2, log2 of entry count (DEPTH=2**DEPTH_W, DEPTH_W>=1).
REQ-004 SHALL have port clk_i, input, 1, sole clock, rising edge.
REQ-005 SHALL have port arst_n_i, input, 1, reset; one clock; reset is asynchronous and active-low.
REQ-006 SHALL have port fe_valid_i, input, 1, write request from cache front end.
REQ-007 SHALL have port fe_addr_i, input, WADDR_W, word address of the write.
REQ-008 SHALL have port fe_wdata_i, input, DATA_W, write data.
REQ-009 SHALL have port fe_wstrb_i, input, NBYTES, byte enables.
REQ-010 SHALL have port fe_ready_o, output, 1, write accepted this cycle when high with fe_valid_i.
REQ-011 SHALL have port valid_o, output, 1, head entry available to the write channel.
REQ-012 SHALL have port addr_o, output, WADDR_W, head entry word address.
REQ-013 SHALL have port wdata_o, output, DATA_W, head entry data.
REQ-014 SHALL have port wstrb_o, output, NBYTES, head entry byte enables.
REQ-015 SHALL have port ready_i, input, 1, write channel consumed the head entry this cycle.
REQ-016 SHALL have ports empty_o and full_o, outputs, 1 each, and level_o, output, DEPTH_W+1, occupied entry count.

Function
REQ-017 SHALL be a first-word-fall-through FIFO of {addr, wdata, wstrb} entries with DEPTH entries and wrap-around read/write pointers.
REQ-018 SHALL drive fe_ready_o = ~full_o; push occurs when fe_valid_i & fe_ready_o.
REQ-019 SHALL drive valid_o = ~empty_o; pop occurs when valid_o & ready_i; ready_i while empty SHALL be ignored.
REQ-020 SHALL present a pushed entry on valid_o/addr_o/wdata_o/wstrb_o exactly one cycle after the push into an empty buffer; no combinational bypass.
REQ-021 SHALL hold addr_o, wdata_o, wstrb_o stable while valid_o is high and ready_i is low.
REQ-022 SHALL on simultaneous push and pop keep level_o unchanged and advance both pointers.
REQ-023 SHALL when full refuse pushes even if a pop occurs the same cycle; full_o deasserts the cycle after the pop.
REQ-024 SHALL update level_o, empty_o and full_o registered, consistent with pointers after each edge; full_o = (level_o == DEPTH).
REQ-025 SHALL preserve write order; entries leave in push order.

Reset
REQ-026 SHALL on arst_n_i low asynchronously clear pointers and level_o to 0, set empty_o=1, full_o=0, valid_o=0, fe_ready_o=1.
REQ-027 SHALL not reset the entry storage; addr_o/wdata_o/wstrb_o are don't-care while valid_o=0.
REQ-028 SHALL discard all buffered entries when reset asserts mid-operation; first valid_o after reset carries the first post-reset push.

Configuration
REQ-029 SHALL support macro IOB_CACHE_WBUF_MERGE_EN selecting write merging.
REQ-030 With IOB_CACHE_WBUF_MERGE_EN defined, a push whose fe_addr_i equals the newest entry's address SHALL merge into that entry (per byte: strobed bytes overwrite, wstrb ORed) without changing level_o, provided the newest entry is not the head being popped that cycle; otherwise a normal push occurs.
REQ-031 A merge SHALL be accepted only when fe_ready_o is high (never while full).
REQ-032 Without IOB_CACHE_WBUF_MERGE_EN every accepted write SHALL occupy a new entry; no address comparator is built.

Verification
REQ-033 Reset then push addr 0x10, data 0xAABBCCDD, wstrb 0xF, ready_i=0 -> valid_o=1 next cycle, addr_o=0x10, level_o=1, outputs stable until ready_i.
REQ-034 DEPTH_W=2, push 4 entries with ready_i=0 -> full_o=1, fe_ready_o=0; fifth fe_valid_i not accepted; drain yields the 4 entries in order, then empty_o=1.
REQ-035 Level 2, push and pop same cycle -> level_o stays 2; popped entry is old head; new entry last out.
REQ-036 MERGE_EN: push addr 0x20 data 0x000000AA wstrb 0x1, then addr 0x20 data 0x0000BB00 wstrb 0x2 -> level_o=1, head wdata low 16 bits 0xBBAA, wstrb 0x3; without macro -> level_o=2.
REQ-037 Level 3, assert arst_n_i low for one cycle -> empty_o=1, valid_o=0, level_o=0 immediately; next push appears alone at head.
